sdc_controller_core: RTL and testbench
======================================

// Module: sdc_controller_core
// PURPOSE
// - Byte-wide host register file for the SD-card controller.
// - The host presents an 8-bit address and an 8-bit data byte every clk.
//   addr[7]=1 means write, addr[7]=0 means read.
// - Holds 32-bit-aligned configuration registers and drives their values to the
//   command/data engines. Returns read data and generates the interrupt request.
// PARAMETERS
// - BLKSIZE_RST  12'h200  reset value of blksize register
// - TIMEOUT_RST  24'h0    reset value of cmd_timeout register
// PORTS
// - clk              in   1    single clock, all logic on rising edge
// - rst              in   1    reset: synchronous, active-low (0 = reset)
// - addr             in   8    [7]=write enable, [6:2]=register index, [1:0]=byte lane
// - data_in          in   8    write byte
// - data_out         out  8    registered read byte
// - response_i       in   128  card response, read-only window
// - cmd_event_i      in   5    command event status, read-only
// - data_event_i     in   5    data event status, read-only
// - argument_o       out  32   command argument
// - command_o        out  14   command register
// - cmd_start_o      out  1    1-cycle pulse per clk in which offset 0x04 is written
// - cmd_timeout_o    out  24   command timeout
// - clock_divider_o  out  8    SD clock divider
// - soft_reset_o     out  1    controller soft reset
// - cmd_isr_en_o     out  5    command interrupt enables
// - data_isr_en_o    out  5    data interrupt enables
// - blksize_o        out  12   block size
// - blkcnt_o         out  16   block count
// - irq_o            out  1    interrupt request
// BEHAVIOUR
// - Register map (byte offsets = addr[6:0]; little-endian lanes, offset+0 = bits[7:0]):
//   - 0x00 argument RW32; 0x04 command RW14; 0x08/0x0C/0x10/0x14 response[31:0..127:96] RO
//   - 0x20 cmd_timeout RW24; 0x24 clock_divider RW8; 0x28 soft_reset RW1
//   - 0x34 cmd_event RO5; 0x38 cmd_isr_en RW5; 0x3C data_event RO5
//   - 0x40 data_isr_en RW5; 0x44 blksize RW12; 0x48 blkcnt RW16
// - Write: on a rising clk with rst=1 and addr[7]=1, the lane addr[1:0] of the
//   register at addr[6:2] takes data_in.
//   - Bits above the register width are discarded and always read 0.
//   - Writes to RO or unmapped offsets are ignored.
//   - Holding a write address for N cycles rewrites the same byte N times (idempotent).
// - cmd_start_o: 1 in the cycle after every clk edge that wrote offset 0x04;
//   stays high for consecutive cycles while the write is held.
// - Read: addr[7]=0 -> data_out = addressed byte, one clk later (1-cycle latency).
//   - Unmapped offsets read 0x00.
//   - data_out holds its value during writes.
// - irq_o: registered; irq_o = |(cmd_event_i & cmd_isr_en) | |(data_event_i & data_isr_en).
// - Reset (rst=0 at clk edge) has priority over writes. All registers are 0 except:
//   - blksize = BLKSIZE_RST
//   - cmd_timeout = TIMEOUT_RST
//   - soft_reset = 1
//   - data_out, cmd_start_o and irq_o are 0.
// - Reset asserted during a held write: that cycle's write is lost; the write
//   resumes after release.
// - An unknown (X) addr before the first drive must not corrupt registers while
//   rst=0.
// STRUCTURE
// - Package sdc_regs_pkg: offset localparams (ADDR_ARGUMENT=7'h00 ... ADDR_BLKCNT=7'h48),
//   register widths, and reset constants.
// - Sub-module sdc_byte_reg #(W, RST): W-bit register, byte-lane write
//   (we, lane, byte_in), synchronous active-low reset; one instance per RW register.
// - Top level: address decode, read mux plus data_out flop, cmd_start and irq logic.
// TESTING
// - Reset pulse, addr=0x00 -> data_out=0x00; addr=0x44 -> 0x00; addr=0x45 -> 0x02;
//   soft_reset_o=1.
// - addr=0x80, data_in=0x55 for 4 clk -> argument_o=0x0000_0055; read 0x00 -> 0x55.
// - addr=0x83, data_in=0x35 -> argument_o=0x3500_0055;
//   then addr=0x84 for 4 clk -> command_o=0x0035 and cmd_start_o high 4 cycles.
// - addr=0x05 -> data_out=0x00, 1 clk later; command_o unchanged.
// - addr=0xB8, data_in=0x1B -> cmd_isr_en_o=0x1B; cmd_event_i=0x01 -> irq_o=1 next clk.
// - Write to 0x88 (RO) and 0xFC (unmapped) -> no state change; reads of 0x7C return 0x00.

Source files
------------

// File: rtl/sdc_regs_pkg.sv
// -----------------------------------------------------------------------------
// sdc_regs_pkg
// Shared definitions for the SD-card controller host register file:
//   - byte offsets of every register in the 7-bit host address space
//   - the 5-bit register index (offset[6:2]) of each register
//   - register widths and default reset constants
// -----------------------------------------------------------------------------
package sdc_regs_pkg;

  // Byte offsets (addr[6:0]); every register is 32-bit aligned.
  localparam logic [6:0] ADDR_ARGUMENT    = 7'h00;
  localparam logic [6:0] ADDR_COMMAND     = 7'h04;
  localparam logic [6:0] ADDR_RESP0       = 7'h08;
  localparam logic [6:0] ADDR_RESP1       = 7'h0C;
  localparam logic [6:0] ADDR_RESP2       = 7'h10;
  localparam logic [6:0] ADDR_RESP3       = 7'h14;
  localparam logic [6:0] ADDR_TIMEOUT     = 7'h20;
  localparam logic [6:0] ADDR_CLKDIV      = 7'h24;
  localparam logic [6:0] ADDR_SOFTRST     = 7'h28;
  localparam logic [6:0] ADDR_CMD_EVENT   = 7'h34;
  localparam logic [6:0] ADDR_CMD_ISR_EN  = 7'h38;
  localparam logic [6:0] ADDR_DATA_EVENT  = 7'h3C;
  localparam logic [6:0] ADDR_DATA_ISR_EN = 7'h40;
  localparam logic [6:0] ADDR_BLKSIZE     = 7'h44;
  localparam logic [6:0] ADDR_BLKCNT      = 7'h48;

  // Register index = word address; the decoder compares addr[6:2] against these.
  localparam logic [4:0] IDX_ARGUMENT    = ADDR_ARGUMENT[6:2];
  localparam logic [4:0] IDX_COMMAND     = ADDR_COMMAND[6:2];
  localparam logic [4:0] IDX_RESP0       = ADDR_RESP0[6:2];
  localparam logic [4:0] IDX_RESP1       = ADDR_RESP1[6:2];
  localparam logic [4:0] IDX_RESP2       = ADDR_RESP2[6:2];
  localparam logic [4:0] IDX_RESP3       = ADDR_RESP3[6:2];
  localparam logic [4:0] IDX_TIMEOUT     = ADDR_TIMEOUT[6:2];
  localparam logic [4:0] IDX_CLKDIV      = ADDR_CLKDIV[6:2];
  localparam logic [4:0] IDX_SOFTRST     = ADDR_SOFTRST[6:2];
  localparam logic [4:0] IDX_CMD_EVENT   = ADDR_CMD_EVENT[6:2];
  localparam logic [4:0] IDX_CMD_ISR_EN  = ADDR_CMD_ISR_EN[6:2];
  localparam logic [4:0] IDX_DATA_EVENT  = ADDR_DATA_EVENT[6:2];
  localparam logic [4:0] IDX_DATA_ISR_EN = ADDR_DATA_ISR_EN[6:2];
  localparam logic [4:0] IDX_BLKSIZE     = ADDR_BLKSIZE[6:2];
  localparam logic [4:0] IDX_BLKCNT      = ADDR_BLKCNT[6:2];

  // Register widths.
  localparam int unsigned W_ARGUMENT = 32;
  localparam int unsigned W_COMMAND  = 14;
  localparam int unsigned W_TIMEOUT  = 24;
  localparam int unsigned W_CLKDIV   = 8;
  localparam int unsigned W_SOFTRST  = 1;
  localparam int unsigned W_EVENT    = 5;
  localparam int unsigned W_BLKSIZE  = 12;
  localparam int unsigned W_BLKCNT   = 16;

  // Default reset constants.
  localparam logic [W_BLKSIZE-1:0] BLKSIZE_RST_DEF = 12'h200;
  localparam logic [W_TIMEOUT-1:0] TIMEOUT_RST_DEF = 24'h0;
  localparam logic [W_SOFTRST-1:0] SOFTRST_RST     = 1'b1;

endpackage

// File: rtl/sdc_controller_core_if.sv
// -----------------------------------------------------------------------------
// sdc_controller_core_if
// Host byte bus of the register file.
//   addr     : [7]=write enable, [6:2]=register index, [1:0]=byte lane
//   data_in  : write byte
//   data_out : registered read byte (one clk latency)
// The host side uses the master modport, the register file the slave modport.
// -----------------------------------------------------------------------------
interface sdc_controller_core_if;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output addr, output data_in, input data_out);
  modport slave  (input addr, input data_in, output data_out);
endinterface

// File: rtl/sdc_byte_reg.sv
// -----------------------------------------------------------------------------
// sdc_byte_reg
// W-bit (W <= 32) configuration register with byte-lane write access.
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset, loads RST
//   we      : write strobe
//   lane    : byte lane written when we=1 (lane 0 = bits [7:0])
//   byte_in : write byte; bits landing above W are dropped
//   q_o     : register value
// -----------------------------------------------------------------------------
module sdc_byte_reg #(
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [1:0]   lane,
  input  logic [7:0]   byte_in,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Narrow registers (W < 8) never look at the upper write bits.
  logic unused_byte_in;
  assign unused_byte_in = ^byte_in;

  // Each bit belongs to exactly one lane; bits outside the addressed lane hold.
  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    assign q_d[i] = (we && (lane == 2'(i / 8))) ? byte_in[i % 8] : q_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  // NOTE: reset is synchronous and has priority over the write path, so a
  // held write is simply lost for the reset cycle and resumes afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= RST;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sdc_controller_core.sv
// -----------------------------------------------------------------------------
// sdc_controller_core
// Byte-wide host register file of the SD-card controller.
//   clk, rst        : clock and synchronous active-low reset
//   host            : host byte bus (addr / data_in / data_out)
//   response_i      : 128-bit card response, read-only at 0x08..0x14
//   cmd_event_i     : command event status, read-only at 0x34
//   data_event_i    : data event status, read-only at 0x3C
//   argument_o ..   : configuration register values to the engines
//   cmd_start_o     : high the cycle after every edge that wrote offset 0x04
//   irq_o           : registered OR of enabled command/data events
// -----------------------------------------------------------------------------
module sdc_controller_core
  import sdc_regs_pkg::*;
#(
  parameter logic [11:0] BLKSIZE_RST = BLKSIZE_RST_DEF,
  parameter logic [23:0] TIMEOUT_RST = TIMEOUT_RST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  sdc_controller_core_if.slave  host,
  input  logic [127:0]          response_i,
  input  logic [W_EVENT-1:0]    cmd_event_i,
  input  logic [W_EVENT-1:0]    data_event_i,
  output logic [W_ARGUMENT-1:0] argument_o,
  output logic [W_COMMAND-1:0]  command_o,
  output logic                  cmd_start_o,
  output logic [W_TIMEOUT-1:0]  cmd_timeout_o,
  output logic [W_CLKDIV-1:0]   clock_divider_o,
  output logic                  soft_reset_o,
  output logic [W_EVENT-1:0]    cmd_isr_en_o,
  output logic [W_EVENT-1:0]    data_isr_en_o,
  output logic [W_BLKSIZE-1:0]  blksize_o,
  output logic [W_BLKCNT-1:0]   blkcnt_o,
  output logic                  irq_o
);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       wr;
  logic [4:0] idx;
  logic [1:0] lane;

  assign wr   = host.addr[7];
  assign idx  = host.addr[6:2];
  assign lane = host.addr[1:0];

  logic we_argument, we_command, we_timeout, we_clkdiv, we_softrst;
  logic we_cmd_isr_en, we_data_isr_en, we_blksize, we_blkcnt;

  assign we_argument    = wr && (idx == IDX_ARGUMENT);
  assign we_command     = wr && (idx == IDX_COMMAND);
  assign we_timeout     = wr && (idx == IDX_TIMEOUT);
  assign we_clkdiv      = wr && (idx == IDX_CLKDIV);
  assign we_softrst     = wr && (idx == IDX_SOFTRST);
  assign we_cmd_isr_en  = wr && (idx == IDX_CMD_ISR_EN);
  assign we_data_isr_en = wr && (idx == IDX_DATA_ISR_EN);
  assign we_blksize     = wr && (idx == IDX_BLKSIZE);
  assign we_blkcnt      = wr && (idx == IDX_BLKCNT);

  // ---------------------------------------------------------------------------
  // RW registers
  // ---------------------------------------------------------------------------
  sdc_byte_reg #(.W(W_ARGUMENT), .RST('0)) u_argument (
    .clk(clk), .rst(rst), .we(we_argument), .lane(lane),
    .byte_in(host.data_in), .q_o(argument_o));

  sdc_byte_reg #(.W(W_COMMAND), .RST('0)) u_command (
    .clk(clk), .rst(rst), .we(we_command), .lane(lane),
    .byte_in(host.data_in), .q_o(command_o));

  sdc_byte_reg #(.W(W_TIMEOUT), .RST(TIMEOUT_RST)) u_timeout (
    .clk(clk), .rst(rst), .we(we_timeout), .lane(lane),
    .byte_in(host.data_in), .q_o(cmd_timeout_o));

  sdc_byte_reg #(.W(W_CLKDIV), .RST('0)) u_clkdiv (
    .clk(clk), .rst(rst), .we(we_clkdiv), .lane(lane),
    .byte_in(host.data_in), .q_o(clock_divider_o));

  sdc_byte_reg #(.W(W_SOFTRST), .RST(SOFTRST_RST)) u_softrst (
    .clk(clk), .rst(rst), .we(we_softrst), .lane(lane),
    .byte_in(host.data_in), .q_o(soft_reset_o));

  sdc_byte_reg #(.W(W_EVENT), .RST('0)) u_cmd_isr_en (
    .clk(clk), .rst(rst), .we(we_cmd_isr_en), .lane(lane),
    .byte_in(host.data_in), .q_o(cmd_isr_en_o));

  sdc_byte_reg #(.W(W_EVENT), .RST('0)) u_data_isr_en (
    .clk(clk), .rst(rst), .we(we_data_isr_en), .lane(lane),
    .byte_in(host.data_in), .q_o(data_isr_en_o));

  sdc_byte_reg #(.W(W_BLKSIZE), .RST(BLKSIZE_RST)) u_blksize (
    .clk(clk), .rst(rst), .we(we_blksize), .lane(lane),
    .byte_in(host.data_in), .q_o(blksize_o));

  sdc_byte_reg #(.W(W_BLKCNT), .RST('0)) u_blkcnt (
    .clk(clk), .rst(rst), .we(we_blkcnt), .lane(lane),
    .byte_in(host.data_in), .q_o(blkcnt_o));

  // ---------------------------------------------------------------------------
  // Read mux: select the 32-bit word, then the byte lane
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [7:0]  data_out_q, data_out_d;
  logic        cmd_start_q, cmd_start_d;
  logic        irq_q, irq_d;

  // NOTE: every variable gets a default at the top of the block so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    rd_word = '0;
    case (idx)
      IDX_ARGUMENT:    rd_word = argument_o;
      IDX_COMMAND:     rd_word = 32'(command_o);
      IDX_RESP0:       rd_word = response_i[31:0];
      IDX_RESP1:       rd_word = response_i[63:32];
      IDX_RESP2:       rd_word = response_i[95:64];
      IDX_RESP3:       rd_word = response_i[127:96];
      IDX_TIMEOUT:     rd_word = 32'(cmd_timeout_o);
      IDX_CLKDIV:      rd_word = 32'(clock_divider_o);
      IDX_SOFTRST:     rd_word = 32'(soft_reset_o);
      IDX_CMD_EVENT:   rd_word = 32'(cmd_event_i);
      IDX_CMD_ISR_EN:  rd_word = 32'(cmd_isr_en_o);
      IDX_DATA_EVENT:  rd_word = 32'(data_event_i);
      IDX_DATA_ISR_EN: rd_word = 32'(data_isr_en_o);
      IDX_BLKSIZE:     rd_word = 32'(blksize_o);
      IDX_BLKCNT:      rd_word = 32'(blkcnt_o);
      default:         rd_word = '0;
    endcase

    rd_byte = rd_word[8*lane +: 8];

    // data_out only follows reads; a write cycle keeps the last read byte.
    data_out_d  = wr ? data_out_q : rd_byte;
    cmd_start_d = we_command;
    irq_d       = (|(cmd_event_i & cmd_isr_en_o)) | (|(data_event_i & data_isr_en_o));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_q  <= '0;
      cmd_start_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      cmd_start_q <= cmd_start_d;
      irq_q       <= irq_d;
    end
  end

  assign host.data_out = data_out_q;
  assign cmd_start_o   = cmd_start_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_sdc_controller_core.sv
// -----------------------------------------------------------------------------
// tb_sdc_controller_core
// Self-checking bench for the SD-card controller host register file.
// -----------------------------------------------------------------------------
module tb_sdc_controller_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] response_i;
  logic [4:0]   cmd_event_i;
  logic [4:0]   data_event_i;
  logic [31:0]  argument_o;
  logic [13:0]  command_o;
  logic         cmd_start_o;
  logic [23:0]  cmd_timeout_o;
  logic [7:0]   clock_divider_o;
  logic         soft_reset_o;
  logic [4:0]   cmd_isr_en_o;
  logic [4:0]   data_isr_en_o;
  logic [11:0]  blksize_o;
  logic [15:0]  blkcnt_o;
  logic         irq_o;

  sdc_controller_core_if host ();

  sdc_controller_core dut (
    .clk             (clk),
    .rst             (rst),
    .host            (host),
    .response_i      (response_i),
    .cmd_event_i     (cmd_event_i),
    .data_event_i    (data_event_i),
    .argument_o      (argument_o),
    .command_o       (command_o),
    .cmd_start_o     (cmd_start_o),
    .cmd_timeout_o   (cmd_timeout_o),
    .clock_divider_o (clock_divider_o),
    .soft_reset_o    (soft_reset_o),
    .cmd_isr_en_o    (cmd_isr_en_o),
    .data_isr_en_o   (data_isr_en_o),
    .blksize_o       (blksize_o),
    .blkcnt_o        (blkcnt_o),
    .irq_o           (irq_o)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] sb_q[$];   // expected data_out after each applied cycle
  logic [7:0] last_rd;   // model of the byte data_out currently holds

  typedef struct {
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] exp;     // expected read byte; ignored for writes
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one bus cycle, push the expected data_out, then pop and compare
  // once the edge has been taken.
  task automatic apply(input logic [7:0] addr, input logic [7:0] din, input logic [7:0] exp_rd);
    logic [7:0] exp_do;
    @(negedge clk);
    host.addr    = addr;
    host.data_in = din;
    exp_do  = addr[7] ? last_rd : exp_rd;
    last_rd = exp_do;
    sb_q.push_back(exp_do);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      check($sformatf("data_out@%02h", addr), 32'(host.data_out), 32'(sb_q.pop_front()));
    end
  endtask

  vec_t vecs[$];

  initial begin
    response_i   = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    cmd_event_i  = 5'h00;
    data_event_i = 5'h12;
    rst          = 1'b0;
    host.addr    = 'x;
    host.data_in = 'x;
    last_rd      = 8'h00;

    // ---- Reset with an undriven address ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    host.addr    = 8'h00;
    host.data_in = 8'h00;
    @(posedge clk);
    #1;
    check("rst_data_out",   32'(host.data_out), 32'h00);
    check("rst_soft_reset", 32'(soft_reset_o),  32'h1);
    check("rst_blksize",    32'(blksize_o),     32'h200);
    check("rst_timeout",    32'(cmd_timeout_o), 32'h0);
    check("rst_argument",   argument_o,         32'h0);
    check("rst_cmd_start",  32'(cmd_start_o),   32'h0);
    check("rst_irq",        32'(irq_o),         32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ---- Table-driven reads and lane writes ----
    vecs = '{
      '{8'h00, 8'h00, 8'h00}, '{8'h44, 8'h00, 8'h00}, '{8'h45, 8'h00, 8'h02},
      '{8'h28, 8'h00, 8'h01}, '{8'h29, 8'h00, 8'h00}, '{8'h20, 8'h00, 8'h00},
      '{8'h08, 8'h00, 8'h0F}, '{8'h0B, 8'h00, 8'h3C}, '{8'h0D, 8'h00, 8'h5A},
      '{8'h12, 8'h00, 8'hA5}, '{8'h17, 8'h00, 8'hF0}, '{8'h3C, 8'h00, 8'h12},
      '{8'h34, 8'h00, 8'h00}, '{8'h7C, 8'h00, 8'h00}, '{8'h4A, 8'h00, 8'h00},
      '{8'hC9, 8'hAB, 8'h00}, '{8'h49, 8'h00, 8'hAB}, '{8'hC4, 8'h77, 8'h00},
      '{8'hC5, 8'hFF, 8'h00}, '{8'h45, 8'h00, 8'h0F}, '{8'h44, 8'h00, 8'h77},
      '{8'hA2, 8'h99, 8'h00}, '{8'hA3, 8'h11, 8'h00}, '{8'h23, 8'h00, 8'h00},
      '{8'h22, 8'h00, 8'h99}, '{8'hA8, 8'h00, 8'h00}, '{8'h28, 8'h00, 8'h00},
      '{8'hA8, 8'hFE, 8'h00}, '{8'h28, 8'h00, 8'h00}
    };
    foreach (vecs[i]) apply(vecs[i].addr, vecs[i].din, vecs[i].exp);
    check("tbl_blkcnt",     32'(blkcnt_o),      32'hAB00);
    check("tbl_blksize",    32'(blksize_o),     32'hF77);
    check("tbl_timeout",    32'(cmd_timeout_o), 32'h990000);
    check("tbl_soft_reset", 32'(soft_reset_o),  32'h0);

    // ---- Held write to argument lane 0 ----
    for (int i = 0; i < 4; i++) begin
      apply(8'h80, 8'h55, 8'h00);
      check("arg_held", argument_o, 32'h0000_0055);
      check("arg_no_start", 32'(cmd_start_o), 32'h0);
    end
    apply(8'h00, 8'h00, 8'h55);

    // ---- Argument lane 3, then held command write ----
    apply(8'h83, 8'h35, 8'h00);
    check("arg_lane3", argument_o, 32'h3500_0055);
    for (int i = 0; i < 4; i++) begin
      apply(8'h84, 8'h35, 8'h00);
      check("cmd_start_held", 32'(cmd_start_o), 32'h1);
      check("command_held",   32'(command_o),   32'h0035);
    end
    apply(8'h05, 8'h00, 8'h00);
    check("cmd_start_drop", 32'(cmd_start_o), 32'h0);
    check("command_kept",   32'(command_o),   32'h0035);
    apply(8'h85, 8'hFF, 8'h00);
    check("command_trunc",  32'(command_o),   32'h3F35);
    apply(8'h05, 8'h00, 8'h3F);

    // ---- Interrupts ----
    apply(8'hB8, 8'h1B, 8'h00);
    check("cmd_isr_en", 32'(cmd_isr_en_o), 32'h1B);
    check("irq_idle",   32'(irq_o),        32'h0);
    cmd_event_i = 5'h01;
    #1;
    check("irq_registered", 32'(irq_o), 32'h0);
    apply(8'h38, 8'h00, 8'h1B);
    check("irq_cmd", 32'(irq_o), 32'h1);
    cmd_event_i = 5'h00;
    apply(8'h34, 8'h00, 8'h00);
    check("irq_cmd_clear", 32'(irq_o), 32'h0);
    apply(8'hC0, 8'h02, 8'h00);
    check("data_isr_en",  32'(data_isr_en_o), 32'h02);
    check("irq_lag",      32'(irq_o),         32'h0);
    apply(8'h40, 8'h00, 8'h02);
    check("irq_data",     32'(irq_o),         32'h1);

    // ---- Writes to read-only and unmapped offsets ----
    apply(8'h88, 8'hAA, 8'h00);
    apply(8'hFC, 8'hAA, 8'h00);
    apply(8'hBC, 8'h1F, 8'h00);
    apply(8'h08, 8'h00, 8'h0F);
    apply(8'h7C, 8'h00, 8'h00);
    apply(8'h3C, 8'h00, 8'h12);
    check("ro_argument", argument_o,         32'h3500_0055);
    check("ro_command",  32'(command_o),     32'h3F35);
    check("ro_blksize",  32'(blksize_o),     32'hF77);
    check("ro_blkcnt",   32'(blkcnt_o),      32'hAB00);
    check("ro_timeout",  32'(cmd_timeout_o), 32'h990000);

    // ---- Reset during a held write ----
    apply(8'hA4, 8'h3C, 8'h00);
    check("clkdiv_write", 32'(clock_divider_o), 32'h3C);
    @(negedge clk);
    host.addr    = 8'hA4;
    host.data_in = 8'h5A;
    rst          = 1'b0;
    @(posedge clk);
    #1;
    check("rstw_clkdiv",     32'(clock_divider_o), 32'h00);
    check("rstw_argument",   argument_o,           32'h0);
    check("rstw_soft_reset", 32'(soft_reset_o),    32'h1);
    check("rstw_blksize",    32'(blksize_o),       32'h200);
    check("rstw_data_out",   32'(host.data_out),   32'h00);
    check("rstw_irq",        32'(irq_o),           32'h0);
    @(negedge clk);
    rst     = 1'b1;
    last_rd = 8'h00;
    @(posedge clk);
    #1;
    check("rstw_resume", 32'(clock_divider_o), 32'h5A);
    apply(8'h24, 8'h00, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
